pc_seq_stack: RTL and testbench

Parametrised program-sequencing unit for the 4-bit controller family: a paged program counter whose in-page part advances as a linear-feedback sequence, plus a configurable-depth hardware return stack with depth tracking and sticky overflow/underflow flags. It generalises the fixed 6+4-bit counter and 4-deep shift-register stack of the current core into one reusable block. It sits between the instruction decoder, which issues one sequencing op per machine cycle, and the ROM address mux.

---
 rtl/pcstk_pkg.sv | 27 ++
 rtl/pcstk_lifo.sv | 64 ++++++
 rtl/pc_seq_stack.sv | 114 +++++++++++
 tb/tb_pc_seq_stack.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pcstk_pkg.sv
// Shared types and helpers for the paged PC / return-stack sequencer.
// Holds the op encoding, default constants and the in-page LFSR successor function.
package pcstk_pkg;

    typedef enum logic [2:0] {
        OP_STEP   = 3'd0,
        OP_JMP    = 3'd1,
        OP_CALL   = 3'd2,
        OP_RET    = 3'd3,
        OP_LDPAGE = 3'd4,
        OP_HOLD   = 3'd5
    } op_e;

    localparam int unsigned    PCSTK_MAX_PL_W       = 8;
    localparam logic [7:0]     PCSTK_DEF_TAPS       = 8'b0000_0011;
    localparam logic [5:0]     PCSTK_DEF_CALL_PAGE  = '1;

    // pl and taps must be zero above bit w-1; feedback enters at the MSB.
    function automatic logic [7:0] lfsr_step(input logic [7:0] pl,
                                             input logic [7:0] taps,
                                             input int unsigned w);
        logic fb;
        fb = ~^(pl & taps);
        return (pl >> 1) | (8'(fb) << (w - 1));
    endfunction

endpackage

// File: rtl/pcstk_lifo.sv
// Return-address shift stack with saturating depth count and sticky ovf/unf flags.
// Latency: one cycle, all outputs registered. Backpressure: none; ena=0 holds all state.
module pcstk_lifo
    import pcstk_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 10,
    parameter int unsigned DW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    input  logic          clr_flags,
    output logic [W-1:0]  top,
    output logic [DW-1:0] depth,
    output logic          ovf,
    output logic          unf
);

    logic [W-1:0]  ent [DEPTH];
    logic [DW-1:0] depth_q;
    logic          ovf_q;
    logic          unf_q;
    logic          full;
    logic          empty;
    logic          ovf_ev;
    logic          unf_ev;

    assign full   = (depth_q == DW'(DEPTH));
    assign empty  = (depth_q == '0);
    assign ovf_ev = push && full;
    assign unf_ev = pop && empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (ena) begin
            if (push) begin
                ent[0] <= din;
                for (int i = 1; i < DEPTH; i++) ent[i] <= ent[i-1];
                if (!full) depth_q <= depth_q + DW'(1);
            end else if (pop) begin
                // Bottom entry keeps its value so repeated pops replicate it.
                for (int i = 0; i < DEPTH - 1; i++) ent[i] <= ent[i+1];
                if (!empty) depth_q <= depth_q - DW'(1);
            end
            // A same-cycle event beats the clear.
            ovf_q <= ovf_ev | (ovf_q & ~clr_flags);
            unf_q <= unf_ev | (unf_q & ~clr_flags);
        end
    end

    assign top   = ent[0];
    assign depth = depth_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule

// File: rtl/pc_seq_stack.sv
// Paged program counter with hardware return stack; PCSTK_LFSR_EN selects XNOR-LFSR STEP, else +1.
// Latency: op effect visible on all outputs one cycle after the sampling edge. Backpressure: none; ena=0 freezes.
module pc_seq_stack
    import pcstk_pkg::*;
#(
    parameter int unsigned      PL_W      = 6,
    parameter int unsigned      PU_W      = 4,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [PL_W-1:0]  TAPS      = PL_W'(PCSTK_DEF_TAPS),
    parameter logic [PU_W-1:0]  CALL_PAGE = PU_W'(PCSTK_DEF_CALL_PAGE)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ena,
    input  logic [2:0]                   op,
    input  logic [PL_W-1:0]              tgt_pl,
    input  logic [PU_W-1:0]              tgt_pu,
    input  logic                         clr_flags,
    output logic [PL_W+PU_W-1:0]         pc,
    output logic [PL_W+PU_W-1:0]         top,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         ovf,
    output logic                         unf,
    output logic                         page_pend
);

    localparam int unsigned PC_W = PL_W + PU_W;

    logic [PL_W-1:0] pl_q, pl_n;
    logic [PU_W-1:0] pu_q, pu_n;
    logic [PU_W-1:0] pend_pu_q, pend_pu_n;
    logic            page_pend_q, page_pend_n;
    logic [PL_W-1:0] pl_step;
    logic            push;
    logic            pop;
    logic [PC_W-1:0] stk_top;

`ifdef PCSTK_LFSR_EN
    assign pl_step = PL_W'(lfsr_step(8'(pl_q), 8'(TAPS), PL_W));
`else
    logic unused_taps;
    assign unused_taps = ^TAPS;
    assign pl_step     = pl_q + PL_W'(1);
`endif

    always_comb begin
        pl_n        = pl_q;
        pu_n        = pu_q;
        pend_pu_n   = pend_pu_q;
        page_pend_n = page_pend_q;
        push        = 1'b0;
        pop         = 1'b0;
        case (op)
            OP_STEP: pl_n = pl_step;
            OP_JMP: begin
                pl_n        = tgt_pl;
                pu_n        = page_pend_q ? pend_pu_q : pu_q;
                page_pend_n = 1'b0;
            end
            OP_CALL: begin
                push        = 1'b1;
                pl_n        = tgt_pl;
                pu_n        = page_pend_q ? pend_pu_q : CALL_PAGE;
                page_pend_n = 1'b0;
            end
            OP_RET: begin
                pop          = 1'b1;
                {pu_n, pl_n} = stk_top;
            end
            OP_LDPAGE: begin
                pend_pu_n   = tgt_pu;
                page_pend_n = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pl_q        <= '0;
            pu_q        <= '0;
            pend_pu_q   <= '0;
            page_pend_q <= 1'b0;
        end else if (ena) begin
            pl_q        <= pl_n;
            pu_q        <= pu_n;
            pend_pu_q   <= pend_pu_n;
            page_pend_q <= page_pend_n;
        end
    end

    // Return address is the sequential successor within the current page.
    pcstk_lifo #(
        .DEPTH (DEPTH),
        .W     (PC_W)
    ) u_lifo (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .push      (push),
        .pop       (pop),
        .din       ({pu_q, pl_step}),
        .clr_flags (clr_flags),
        .top       (stk_top),
        .depth     (depth),
        .ovf       (ovf),
        .unf       (unf)
    );

    assign pc        = {pu_q, pl_q};
    assign top       = stk_top;
    assign page_pend = page_pend_q;

endmodule

// File: tb/tb_pc_seq_stack.sv
// Directed bench for pc_seq_stack at default parameters; expected values hand-computed for either STEP mode.
module tb_pc_seq_stack;
    import pcstk_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [2:0] op;
    logic [5:0] tgt_pl;
    logic [3:0] tgt_pu;
    logic       clr_flags;
    logic [9:0] pc;
    logic [9:0] top;
    logic [2:0] depth;
    logic       ovf;
    logic       unf;
    logic       page_pend;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef PCSTK_LFSR_EN
    localparam logic [5:0] SEQ  [6] = '{6'h20, 6'h30, 6'h38, 6'h3C, 6'h3E, 6'h1F};
    localparam logic [5:0] LOCK [3] = '{6'h3F, 6'h3F, 6'h3F};
    localparam logic [5:0] S0 = 6'h20, S1 = 6'h00, S2 = 6'h01, S3 = 6'h21, S4 = 6'h22;
`else
    localparam logic [5:0] SEQ  [6] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06};
    localparam logic [5:0] LOCK [3] = '{6'h00, 6'h01, 6'h02};
    localparam logic [5:0] S0 = 6'h01, S1 = 6'h02, S2 = 6'h03, S3 = 6'h04, S4 = 6'h05;
`endif

    pc_seq_stack dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .op        (op),
        .tgt_pl    (tgt_pl),
        .tgt_pu    (tgt_pu),
        .clr_flags (clr_flags),
        .pc        (pc),
        .top       (top),
        .depth     (depth),
        .ovf       (ovf),
        .unf       (unf),
        .page_pend (page_pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input op_e o, input logic [5:0] p, input logic [3:0] u);
        op     = o;
        tgt_pl = p;
        tgt_pu = u;
        cyc();
        op     = OP_HOLD;
    endtask

    function automatic logic [31:0] mk(input logic [3:0] u, input logic [5:0] l);
        return 32'({u, l});
    endfunction

    localparam logic [5:0] RET_PL [5] = '{S4, S3, S2, S1, S1};

    initial begin
        rst = 1'b1; ena = 1'b1; op = OP_HOLD; tgt_pl = '0; tgt_pu = '0; clr_flags = 1'b0;
        cyc(); cyc();
        check("rst_pc",    32'(pc), 32'h0);
        check("rst_top",   32'(top), 32'h0);
        check("rst_depth", 32'(depth), 32'h0);
        check("rst_flags", 32'({ovf, unf, page_pend}), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            drive(OP_STEP, 6'h00, 4'h0);
            check($sformatf("step%0d", i), 32'(pc), mk(4'h0, SEQ[i]));
        end

        drive(OP_LDPAGE, 6'h00, 4'h3);
        check("ldpage_pc_hold", 32'(pc), mk(4'h0, SEQ[5]));
        check("ldpage_pend",    32'(page_pend), 32'h1);
        drive(OP_JMP, 6'h15, 4'h0);
        check("jmp_pend_pc", 32'(pc), mk(4'h3, 6'h15));
        check("jmp_pend_clr", 32'(page_pend), 32'h0);
        drive(OP_JMP, 6'h20, 4'h0);
        check("jmp_nopend_pc", 32'(pc), mk(4'h3, 6'h20));
        drive(OP_LDPAGE, 6'h00, 4'h7);
        drive(OP_LDPAGE, 6'h00, 4'h9);
        drive(OP_JMP, 6'h02, 4'h0);
        check("ldpage_overwrite", 32'(pc), mk(4'h9, 6'h02));

        drive(OP_LDPAGE, 6'h00, 4'h2);
        drive(OP_JMP, 6'h00, 4'h0);
        drive(OP_CALL, 6'h04, 4'h0);
        check("call_pc",    32'(pc), mk(4'hF, 6'h04));
        check("call_top",   32'(top), mk(4'h2, S0));
        check("call_depth", 32'(depth), 32'h1);
        drive(OP_RET, 6'h00, 4'h0);
        check("ret_pc",    32'(pc), mk(4'h2, S0));
        check("ret_depth", 32'(depth), 32'h0);
        check("ret_unf",   32'(unf), 32'h0);

        rst = 1'b1; cyc(); rst = 1'b0;
        for (int i = 1; i <= 4; i++) drive(OP_CALL, 6'(i), 4'h0);
        check("call4_depth", 32'(depth), 32'h4);
        check("call4_ovf",   32'(ovf), 32'h0);
        clr_flags = 1'b1;
        drive(OP_CALL, 6'h05, 4'h0);
        clr_flags = 1'b0;
        check("call5_depth", 32'(depth), 32'h4);
        check("call5_ovf_beats_clr", 32'(ovf), 32'h1);
        check("call5_pc",    32'(pc), mk(4'hF, 6'h05));
        check("call5_top",   32'(top), mk(4'hF, S4));

        ena = 1'b0; clr_flags = 1'b1;
        drive(OP_CALL, 6'h33, 4'h0);
        ena = 1'b1; clr_flags = 1'b0;
        check("ena0_pc",    32'(pc), mk(4'hF, 6'h05));
        check("ena0_depth", 32'(depth), 32'h4);
        check("ena0_ovf",   32'(ovf), 32'h1);
        clr_flags = 1'b1;
        drive(OP_HOLD, 6'h00, 4'h0);
        clr_flags = 1'b0;
        check("clr_ovf", 32'(ovf), 32'h0);

        for (int i = 0; i < 5; i++) begin
            drive(OP_RET, 6'h00, 4'h0);
            check($sformatf("ret%0d_pc", i), 32'(pc), mk(4'hF, RET_PL[i]));
            check($sformatf("ret%0d_depth", i), 32'(depth), 32'((i < 4) ? 3 - i : 0));
            check($sformatf("ret%0d_unf", i), 32'(unf), 32'((i == 4) ? 1 : 0));
        end

        drive(OP_JMP, 6'h3F, 4'h0);
        check("jmp_ones", 32'(pc), mk(4'hF, 6'h3F));
        for (int i = 0; i < 3; i++) begin
            drive(OP_STEP, 6'h00, 4'h0);
            check($sformatf("lock_step%0d", i), 32'(pc), mk(4'hF, LOCK[i]));
        end

        drive(OP_LDPAGE, 6'h00, 4'h5);
        rst = 1'b1;
        drive(OP_CALL, 6'h11, 4'h0);
        rst = 1'b0;
        check("rstcall_pc",    32'(pc), 32'h0);
        check("rstcall_top",   32'(top), 32'h0);
        check("rstcall_depth", 32'(depth), 32'h0);
        check("rstcall_flags", 32'({ovf, unf, page_pend}), 32'h0);

        drive(OP_LDPAGE, 6'h00, 4'h6);
        drive(OP_CALL, 6'h07, 4'h0);
        check("callpend_pc",  32'(pc), mk(4'h6, 6'h07));
        check("callpend_top", 32'(top), mk(4'h0, S0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
